// File: rtl/issue_decode.sv
// N-lane decode/issue stage: splits bundles on intra-bundle RAW hazards,
// registers one operand set per lane, and tracks compare flags.
module issue_decode #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int NREG  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*32-1:0]     in_inst,
    input  logic [NREG*XLEN-1:0]    gpr_flat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [LANES*32-1:0]     out_inst,
    output logic [LANES*XLEN-1:0]   out_srca,
    output logic [LANES*XLEN-1:0]   out_srcb,
    output logic [LANES*XLEN-1:0]   out_srcs,
    output logic [LANES*4-1:0]      out_e_type,
    output logic [LANES*5-1:0]      out_rt,
    output logic [LANES-1:0]        out_rt_flag,
    output logic                    eq,
    output logic                    less
);

    localparam int SW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [31:0] NOP = {3'b111, 29'b0};

    localparam logic [5:0] OP_ADDI  = 6'b000001, OP_SUBI  = 6'b000010;
    localparam logic [5:0] OP_ADD   = 6'b000011, OP_SUB   = 6'b000100;
    localparam logic [5:0] OP_SRAWI = 6'b000101, OP_SLAWI = 6'b000110;
    localparam logic [5:0] OP_LI    = 6'b000111, OP_LIW   = 6'b001000;
    localparam logic [5:0] OP_FADD  = 6'b001100, OP_FSUB  = 6'b001101;
    localparam logic [5:0] OP_FMUL  = 6'b001110, OP_FDIV  = 6'b001111;
    localparam logic [5:0] OP_INLL  = 6'b010000, OP_INLH  = 6'b010001;
    localparam logic [5:0] OP_INUL  = 6'b010010, OP_INUH  = 6'b010011;
    localparam logic [5:0] OP_CMPD  = 6'b011100, OP_CMPDI = 6'b011110;
    localparam logic [5:0] OP_JUMP  = 6'b100100, OP_BLR   = 6'b100101;
    localparam logic [5:0] OP_BL    = 6'b100110, OP_BLRR  = 6'b100111;

    typedef enum logic {RUN, SPLIT} state_t;

    function automatic logic is_branch(input logic [5:0] op);
        return op[5:2] == 4'b1000;
    endfunction

    function automatic logic writes_rt(input logic [5:0] op);
        return op inside {OP_ADDI, OP_SUBI, OP_ADD, OP_SUB, OP_SRAWI,
                          OP_SLAWI, OP_LI, OP_LIW, OP_BL, OP_BLRR,
                          OP_INLL, OP_INLH, OP_INUL, OP_INUH};
    endfunction

    function automatic logic is_ctrl(input logic [5:0] op);
        return (op inside {OP_JUMP, OP_BLR, OP_BL, OP_BLRR}) || is_branch(op);
    endfunction

    function automatic logic [3:0] e_type_of(input logic [5:0] op);
        logic [3:0] e;
        e = 4'd0;
        unique case (1'b1)
            op == OP_ADDI || op == OP_ADD: e = 4'd1;
            op == OP_SUBI || op == OP_SUB: e = 4'd2;
            op == OP_SRAWI:                e = 4'd3;
            op == OP_SLAWI:                e = 4'd4;
            default:                       e = 4'd0;
        endcase
        return e;
    endfunction

    state_t                 state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [LANES-1:0]       lv_q, lv_d, rtf_q, rtf_d;
    logic [LANES*32-1:0]    inst_q, inst_d, buf_q, buf_d;
    logic [LANES*XLEN-1:0]  srca_q, srca_d, srcb_q, srcb_d, srcs_q, srcs_d;
    logic [LANES*4-1:0]     e_type_q, e_type_d;
    logic [LANES*5-1:0]     rt_q, rt_d;
    logic                   eq_q, eq_d, less_q, less_d;
    logic [SW-1:0]          start_q, start_d;

    logic                   load, accept, issue;
    logic [LANES*32-1:0]    src;
    logic [LANES*32+31:0]   src_ext;
    logic [5:0]             op_l   [LANES];
    logic [4:0]             rt_l   [LANES];
    logic [4:0]             ra_l   [LANES];
    logic [4:0]             rb_l   [LANES];
    logic [4:0]             rs_l   [LANES];
    logic [XLEN-1:0]        srca_l [LANES];
    logic [XLEN-1:0]        srcb_l [LANES];
    logic [XLEN-1:0]        srcs_l [LANES];
    logic [LANES-1:0]       rtf_l, eq_l, lt_l, cmp_l;
    logic [LANES-1:0]       lv;
    logic                   cut_found, cmp_hit, cmp_eq, cmp_lt;
    logic [SW-1:0]          cut_idx;

    assign load     = !out_valid_q || out_ready;
    assign in_ready = load && state_q == RUN && !flush;
    assign accept   = in_ready && in_valid;
    assign issue    = !flush && (accept || (state_q == SPLIT && load));
    assign src      = (state_q == SPLIT) ? buf_q : in_inst;
    // Padding word makes Liw in the last lane read a zero immediate.
    assign src_ext  = {32'b0, src};

    always_comb begin
        logic [31:0]     w;
        logic [XLEN-1:0] sext, gb;
        w = '0;
        sext = '0;
        gb = '0;
        for (int k = 0; k < LANES; k++) begin
            w = src[32*k +: 32];
            op_l[k] = w[31:26];
            rs_l[k] = w[25:21];
            ra_l[k] = w[20:16];
            rb_l[k] = w[15:11];
            rt_l[k] = (op_l[k] == OP_BL || op_l[k] == OP_BLRR) ? 5'd31 : w[25:21];
            rtf_l[k] = writes_rt(op_l[k]);
            sext = {{(XLEN-16){w[15]}}, w[15:0]};
            gb = gpr_flat[XLEN*int'(w[15:11]) +: XLEN];
            srca_l[k] = gpr_flat[XLEN*int'(w[20:16]) +: XLEN];
            srcs_l[k] = gpr_flat[XLEN*int'(w[25:21]) +: XLEN];
            unique case (1'b1)
                op_l[k] inside {OP_ADD, OP_SUB, OP_FADD, OP_FSUB,
                                OP_FMUL, OP_FDIV, OP_CMPD}:
                    srcb_l[k] = gb;
                op_l[k] inside {OP_JUMP, OP_BL} || is_branch(op_l[k]):
                    srcb_l[k] = {{(XLEN-26){1'b0}}, w[25:0]};
                op_l[k] == OP_LIW:
                    srcb_l[k] = XLEN'(src_ext[32*(k+1) +: 32]);
                default:
                    srcb_l[k] = sext;
            endcase
            cmp_l[k] = op_l[k] == OP_CMPD || op_l[k] == OP_CMPDI;
            if (op_l[k] == OP_CMPDI) gb = sext;
            eq_l[k] = srca_l[k] == gb;
            lt_l[k] = $signed(srca_l[k]) < $signed(gb);
        end
    end

    // Group formation: drop lanes after a control transfer or Liw
    // immediate, and end the group at the first hazarded lane.
    always_comb begin
        int   s;
        logic stop, ctl, skip, haz;
        s = (state_q == SPLIT) ? int'(start_q) : 0;
        stop = 1'b0;
        ctl = 1'b0;
        skip = 1'b0;
        haz = 1'b0;
        lv = '0;
        cut_found = 1'b0;
        cut_idx = '0;
        for (int k = 0; k < LANES; k++) begin
            haz = 1'b0;
            for (int p = 0; p < k; p++) begin
                if (lv[p] && rtf_l[p] &&
                    (rt_l[p] == ra_l[k] || rt_l[p] == rb_l[k] || rt_l[p] == rs_l[k]))
                    haz = 1'b1;
            end
            if (k >= s && !stop) begin
                if (skip) skip = 1'b0;
                else if (ctl) stop = 1'b1;
                else if (haz) begin
                    cut_found = 1'b1;
                    cut_idx = SW'(k);
                    stop = 1'b1;
                end else begin
                    lv[k] = 1'b1;
                    skip = op_l[k] == OP_LIW;
                    ctl = is_ctrl(op_l[k]);
                end
            end
        end
        cmp_hit = 1'b0;
        cmp_eq = 1'b0;
        cmp_lt = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (lv[k] && cmp_l[k]) begin
                cmp_hit = 1'b1;
                cmp_eq = eq_l[k];
                cmp_lt = lt_l[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) state_d = RUN;
        else begin
            unique case (state_q)
                RUN:   if (accept && cut_found) state_d = SPLIT;
                SPLIT: if (load && !cut_found) state_d = RUN;
            endcase
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        lv_d = lv_q;
        rtf_d = rtf_q;
        inst_d = inst_q;
        srca_d = srca_q;
        srcb_d = srcb_q;
        srcs_d = srcs_q;
        e_type_d = e_type_q;
        rt_d = rt_q;
        eq_d = eq_q;
        less_d = less_q;
        buf_d = buf_q;
        start_d = start_q;
        if (flush) begin
            out_valid_d = 1'b0;
            lv_d = '0;
            rtf_d = '0;
            inst_d = {LANES{NOP}};
            buf_d = '0;
            start_d = '0;
        end else if (issue) begin
            out_valid_d = 1'b1;
            lv_d = lv;
            rtf_d = lv & rtf_l;
            for (int k = 0; k < LANES; k++) begin
                inst_d[32*k +: 32] = lv[k] ? src[32*k +: 32] : NOP;
                srca_d[XLEN*k +: XLEN] = srca_l[k];
                srcb_d[XLEN*k +: XLEN] = srcb_l[k];
                srcs_d[XLEN*k +: XLEN] = srcs_l[k];
                e_type_d[4*k +: 4] = e_type_of(op_l[k]);
                rt_d[5*k +: 5] = rt_l[k];
            end
            if (cmp_hit) begin
                eq_d = cmp_eq;
                less_d = cmp_lt;
            end
            if (accept) buf_d = in_inst;
            start_d = cut_found ? cut_idx : '0;
        end else if (load) begin
            out_valid_d = 1'b0;
            lv_d = '0;
            rtf_d = '0;
            inst_d = {LANES{NOP}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            lv_q <= '0;
            rtf_q <= '0;
            inst_q <= {LANES{NOP}};
            srca_q <= '0;
            srcb_q <= '0;
            srcs_q <= '0;
            e_type_q <= '0;
            rt_q <= '0;
            eq_q <= 1'b0;
            less_q <= 1'b0;
            buf_q <= '0;
            start_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            lv_q <= lv_d;
            rtf_q <= rtf_d;
            inst_q <= inst_d;
            srca_q <= srca_d;
            srcb_q <= srcb_d;
            srcs_q <= srcs_d;
            e_type_q <= e_type_d;
            rt_q <= rt_d;
            eq_q <= eq_d;
            less_q <= less_d;
            buf_q <= buf_d;
            start_q <= start_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_lane_valid = lv_q;
    assign out_rt_flag    = rtf_q;
    assign out_inst       = inst_q;
    assign out_srca       = srca_q;
    assign out_srcb       = srcb_q;
    assign out_srcs       = srcs_q;
    assign out_e_type     = e_type_q;
    assign out_rt         = rt_q;
    assign eq             = eq_q;
    assign less           = less_q;

endmodule

// File: tb/tb_issue_decode.sv
// Directed bench for issue_decode (LANES=2): vector table plus
// hazard split, backpressure, compare, flush and reset sequences.
module tb_issue_decode;

    localparam int L = 2;
    localparam logic [31:0] NOP = 32'hE000_0000;

    localparam logic [5:0] ADDI  = 6'b000001, SUB   = 6'b000100;
    localparam logic [5:0] ADD   = 6'b000011, SRAWI = 6'b000101;
    localparam logic [5:0] SLAWI = 6'b000110, LIW   = 6'b001000;
    localparam logic [5:0] LOAD  = 6'b001001, CMPD  = 6'b011100;
    localparam logic [5:0] CMPDI = 6'b011110, JUMP  = 6'b100100;
    localparam logic [5:0] BL    = 6'b100110;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [L*32-1:0]  in_inst, out_inst;
    logic [32*32-1:0] gpr_flat;
    logic [L-1:0]     out_lane_valid, out_rt_flag;
    logic [L*32-1:0]  out_srca, out_srcb, out_srcs;
    logic [L*4-1:0]   out_e_type;
    logic [L*5-1:0]   out_rt;
    logic             eq, less;

    int checks = 0;
    int errors = 0;

    issue_decode #(.LANES(L), .XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .gpr_flat(gpr_flat), .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_inst(out_inst),
        .out_srca(out_srca), .out_srcb(out_srcb), .out_srcs(out_srcs),
        .out_e_type(out_e_type), .out_rt(out_rt),
        .out_rt_flag(out_rt_flag), .eq(eq), .less(less)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i0, i1;
        logic [1:0]  lv, rtf;
        logic [31:0] a0, b0, a1, b1;
        logic [3:0]  e0, e1;
        logic [4:0]  rt0;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] ra, input logic [15:0] si);
        return {op, rt, ra, si};
    endfunction

    function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [4:0] ra, input logic [4:0] rb);
        return {op, rt, ra, rb, 11'b0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic setr(input int r, input logic [31:0] v);
        gpr_flat[32*r +: 32] = v;
    endtask

    // Present a bundle for one edge, then withdraw it.
    task automatic issue1(input logic [31:0] i0, input logic [31:0] i1);
        in_inst = {i1, i0};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic split_first(input string tag);
        issue1(ri(ADDI, 3, 1, 1), rr(ADD, 5, 3, 2));
        chk({tag, "_g1_lv"}, out_lane_valid, 2'b01);
        chk({tag, "_g1_ready"}, in_ready, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_inst = '0;
        gpr_flat = '0;
        setr(1, 10); setr(2, 7); setr(3, 100); setr(4, 40);
        setr(5, 50); setr(6, 3); setr(9, 9);

        vecs[0] = '{ri(ADDI,3,1,5), rr(SUB,4,2,6), 2'b11, 2'b11,
                    10, 5, 7, 3, 4'd1, 4'd2, 5'd3};
        vecs[1] = '{ri(LIW,7,0,0), 32'hDEADBEEF, 2'b01, 2'b01,
                    0, 32'hDEADBEEF, 0, 0, 4'd0, 4'd0, 5'd7};
        vecs[2] = '{{JUMP, 26'h123}, ri(ADDI,5,1,1), 2'b01, 2'b00,
                    0, 32'h123, 0, 0, 4'd0, 4'd0, 5'd0};
        vecs[3] = '{ri(SRAWI,4,2,2), ri(SLAWI,5,6,16'hFFFF), 2'b11, 2'b11,
                    7, 2, 3, 32'hFFFFFFFF, 4'd3, 4'd4, 5'd4};
        vecs[4] = '{ri(LOAD,9,1,8), rr(ADD,10,9,2), 2'b11, 2'b10,
                    10, 8, 9, 7, 4'd0, 4'd1, 5'd9};
        vecs[5] = '{{BL, 26'h40}, ri(ADDI,5,1,1), 2'b01, 2'b01,
                    0, 32'h40, 0, 0, 4'd0, 4'd0, 5'd31};
        vecs[6] = '{ri(ADDI,3,1,5), ri(LIW,7,2,0), 2'b11, 2'b11,
                    10, 5, 7, 0, 4'd1, 4'd0, 5'd3};
        vecs[7] = '{{6'b100001, 26'h5}, rr(ADD,5,1,2), 2'b01, 2'b00,
                    0, 5, 0, 0, 4'd0, 4'd0, 5'd0};

        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_lv", out_lane_valid, 2'b00);
        chk("rst_rtf", out_rt_flag, 2'b00);
        chk("rst_inst", out_inst, {NOP, NOP});
        chk("rst_srca", out_srca, 64'd0);
        chk("rst_eqless", {eq, less}, 2'b00);
        rst = 1'b0;
        #1;

        for (int v = 0; v < 8; v++) begin
            logic [63:0] ei;
            chk($sformatf("v%0d_ready", v), in_ready, 1'b1);
            issue1(vecs[v].i0, vecs[v].i1);
            ei = {vecs[v].lv[1] ? vecs[v].i1 : NOP, vecs[v].lv[0] ? vecs[v].i0 : NOP};
            chk($sformatf("v%0d_valid", v), out_valid, 1'b1);
            chk($sformatf("v%0d_lv", v), out_lane_valid, vecs[v].lv);
            chk($sformatf("v%0d_rtf", v), out_rt_flag, vecs[v].rtf);
            chk($sformatf("v%0d_inst", v), out_inst, ei);
            chk($sformatf("v%0d_a0", v), out_srca[31:0], vecs[v].a0);
            chk($sformatf("v%0d_b0", v), out_srcb[31:0], vecs[v].b0);
            chk($sformatf("v%0d_e0", v), out_e_type[3:0], vecs[v].e0);
            chk($sformatf("v%0d_rt0", v), out_rt[4:0], vecs[v].rt0);
            if (vecs[v].lv[1]) begin
                chk($sformatf("v%0d_a1", v), out_srca[63:32], vecs[v].a1);
                chk($sformatf("v%0d_b1", v), out_srcb[63:32], vecs[v].b1);
                chk($sformatf("v%0d_e1", v), out_e_type[7:4], vecs[v].e1);
            end
        end

        // Intra-bundle RAW: second group must see the updated r3.
        split_first("haz");
        setr(3, 111);
        @(negedge clk);
        #1;
        chk("haz_g2_valid", out_valid, 1'b1);
        chk("haz_g2_lv", out_lane_valid, 2'b10);
        chk("haz_g2_inst0", out_inst[31:0], NOP);
        chk("haz_g2_a1", out_srca[63:32], 32'd111);
        chk("haz_g2_b1", out_srcb[63:32], 32'd7);
        chk("haz_g2_e1", out_e_type[7:4], 4'd1);
        chk("haz_ready_back", in_ready, 1'b1);

        issue1(vecs[0].i0, vecs[0].i1);
        out_ready = 1'b0;
        in_inst = {vecs[3].i1, vecs[3].i0};
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp%0d_ready", c), in_ready, 1'b0);
            chk($sformatf("bp%0d_a0", c), out_srca[31:0], 32'd10);
            chk($sformatf("bp%0d_e1", c), out_e_type[7:4], 4'd2);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_next_valid", out_valid, 1'b1);
        chk("bp_next_a0", out_srca[31:0], 32'd7);
        chk("bp_next_e0", out_e_type[3:0], 4'd3);
        @(negedge clk);
        #1;
        chk("bp_no_dup", out_valid, 1'b0);

        setr(1, 7); setr(2, 7); setr(4, 40);
        issue1(rr(CMPD, 0, 1, 2), NOP);
        chk("cmpd_eq", {eq, less}, 2'b10);
        setr(1, -5);
        issue1(ri(CMPDI, 0, 1, 16'hFFFF), NOP);
        chk("cmpdi_lt", {eq, less}, 2'b01);
        issue1(ri(CMPDI, 0, 1, 16'hFFFB), NOP);
        chk("cmpdi_eq", {eq, less}, 2'b10);
        setr(1, 7);
        issue1(rr(CMPD, 0, 1, 2), rr(CMPD, 0, 1, 4));
        chk("cmp_youngest", {eq, less}, 2'b01);
        issue1(vecs[0].i0, vecs[0].i1);
        chk("cmp_hold", {eq, less}, 2'b01);

        split_first("fl");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_lv", out_lane_valid, 2'b00);
        chk("fl_rtf", out_rt_flag, 2'b00);
        chk("fl_inst", out_inst, {NOP, NOP});
        chk("fl_flags_hold", {eq, less}, 2'b01);
        chk("fl_ready", in_ready, 1'b1);
        @(negedge clk);
        #1;
        chk("fl_dropped", out_valid, 1'b0);
        flush = 1'b1;
        in_inst = {vecs[0].i1, vecs[0].i0};
        in_valid = 1'b1;
        #1;
        chk("fl_run_ready", in_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl_run_noaccept", out_valid, 1'b0);

        split_first("ar");
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_lv", out_lane_valid, 2'b00);
        chk("ar_inst", out_inst, {NOP, NOP});
        chk("ar_srca", out_srca, 64'd0);
        chk("ar_rt", out_rt, 10'd0);
        chk("ar_etype", out_e_type, 8'd0);
        chk("ar_flags", {eq, less}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_ready", in_ready, 1'b1);
        @(negedge clk);
        #1;
        chk("ar_dropped", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
